// File: rtl/matrix_scan_pkg.sv
// Shared constants, scan FSM encoding and output bundle for the seven-segment matrix scan driver.
package matrix_scan_pkg;

  localparam int FRAME_BITS   = 8192;
  localparam int SEGS_PER_ROW = 128;
  localparam int PWM_PLANES   = 15;
  localparam int INTENSITY_W  = 4;

  localparam int NUM_SEGS  = FRAME_BITS / INTENSITY_W;
  localparam int SEG_IDX_W = $clog2(NUM_SEGS);
  localparam int BIT_IDX_W = $clog2(SEGS_PER_ROW);
  localparam int ROW_IDX_W = SEG_IDX_W - BIT_IDX_W;

  typedef enum logic [1:0] {
    SCAN_SHIFT = 2'd0,
    SCAN_BLANK = 2'd1,
    SCAN_LATCH = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic sr_data;
    logic sr_clk;
    logic sr_latch;
    logic sr_oe_n;
    logic frame_start;
  } scan_out_t;

  localparam scan_out_t SCAN_OUT_RESET = '{
    sr_data:     1'b0,
    sr_clk:      1'b0,
    sr_latch:    1'b0,
    sr_oe_n:     1'b1,
    frame_start: 1'b0
  };

  // Shift bit b walks the row from its top segment (digit 15, seg 7) down to segment 0.
  function automatic logic [SEG_IDX_W-1:0] seg_index(input logic [ROW_IDX_W-1:0] r,
                                                     input logic [BIT_IDX_W-1:0] b);
    return {r, ~b};
  endfunction

endpackage

// File: rtl/matrix_scan_frame_buffer.sv
// Pending/display frame buffers with boundary swap and a 4-bit intensity read port.
module frame_buffer
  import matrix_scan_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FRAME_BITS-1:0]  data_i,
  input  logic                   frame_valid_i,
  input  logic                   swap_i,
  input  logic [SEG_IDX_W-1:0]   rd_idx_i,
  output logic [INTENSITY_W-1:0] rd_intensity_o
);

  logic [FRAME_BITS-1:0] pending_buf_q, pending_buf_d;
  logic [FRAME_BITS-1:0] display_q, display_d;
  logic                  pending_q, pending_d;
  logic                  do_swap;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    pending_buf_d = pending_buf_q;
    display_d     = display_q;
    pending_d     = pending_q;
    do_swap       = swap_i && pending_q;

    // The swap consumes the old pending contents before a same-cycle capture replaces them.
    if (do_swap) begin
      display_d = pending_buf_q;
      pending_d = 1'b0;
    end
    if (frame_valid_i) begin
      pending_buf_d = data_i;
      pending_d     = 1'b1;
    end
  end

  // NOTE: these buffers are flops, not RAM, and are reset so a restarted scan shows a dark matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_buf_q <= '0;
      display_q     <= '0;
      pending_q     <= 1'b0;
    end else begin
      pending_buf_q <= pending_buf_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
    end
  end

  assign rd_intensity_o = display_q[{rd_idx_i, 2'b00} +: INTENSITY_W];

endmodule

// File: rtl/matrix_scan.sv
// Row-multiplexed 4-bit PWM refresh of a 16x16 seven-segment matrix through a 595-style chain.
module matrix_scan
  import matrix_scan_pkg::*;
#(
  parameter int ROWS         = 16,
  parameter int DIGITS       = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] data,
  input  logic                  frame_valid,
  output logic                  sr_data,
  output logic                  sr_clk,
  output logic                  sr_latch,
  output logic                  sr_oe_n,
  output logic [3:0]            row,
  output logic                  frame_start
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(DIGITS * 8 - 1);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW   = ROW_IDX_W'(ROWS - 1);
  localparam logic [3:0]           LAST_PLANE = 4'(PWM_PLANES - 1);
  localparam logic [7:0]           LAST_BLANK = 8'(BLANK_CYCLES - 1);

  scan_state_e            state_q, state_d;
  logic [3:0]             plane_q, plane_d;
  logic [ROW_IDX_W-1:0]   row_cnt_q, row_cnt_d;
  logic [BIT_IDX_W-1:0]   bit_q, bit_d;
  logic                   phase_q, phase_d;
  logic [7:0]             blank_q, blank_d;
  scan_out_t              out_q, out_d;
  logic [3:0]             row_q, row_d;

  logic                   swap;
  logic [INTENSITY_W-1:0] intensity;
  logic                   seg_on;

  frame_buffer u_frame_buffer (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_i         (data),
    .frame_valid_i  (frame_valid),
    .swap_i         (swap),
    .rd_idx_i       (seg_index(row_cnt_q, bit_q)),
    .rd_intensity_o (intensity)
  );

  // A segment lights in plane p while its intensity exceeds p, giving 0..15 of 15 planes.
  assign seg_on = intensity > plane_q;

  always_comb begin
    state_d          = state_q;
    plane_d          = plane_q;
    row_cnt_d        = row_cnt_q;
    bit_d            = bit_q;
    phase_d          = phase_q;
    blank_d          = blank_q;
    out_d            = out_q;
    out_d.sr_latch   = 1'b0;
    out_d.frame_start = 1'b0;
    row_d            = row_q;
    swap             = 1'b0;

    unique case (state_q)
      SCAN_SHIFT: begin
        if (!phase_q) begin
          out_d.sr_data = seg_on;
          out_d.sr_clk  = 1'b0;
          phase_d       = 1'b1;
        end else begin
          out_d.sr_clk = 1'b1;
          phase_d      = 1'b0;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            // Plane 0 is the first plane of a new row, so the outputs go dark for the row change.
            state_d = (plane_q == 4'd0) ? SCAN_BLANK : SCAN_LATCH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      SCAN_BLANK: begin
        out_d.sr_oe_n = 1'b1;
        out_d.sr_clk  = 1'b0;
        if (blank_q == LAST_BLANK) begin
          blank_d = '0;
          state_d = SCAN_LATCH;
        end else begin
          blank_d = blank_q + 8'd1;
        end
      end

      SCAN_LATCH: begin
        out_d.sr_latch    = 1'b1;
        out_d.sr_clk      = 1'b0;
        out_d.sr_oe_n     = 1'b0;
        out_d.frame_start = (row_cnt_q == '0) && (plane_q == 4'd0);
        row_d             = 4'(row_cnt_q);
        state_d           = SCAN_SHIFT;
        if (plane_q == LAST_PLANE) begin
          plane_d = 4'd0;
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            swap      = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end else begin
          plane_d = plane_q + 4'd1;
        end
      end

      default: begin
        state_d = SCAN_SHIFT;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN_SHIFT;
      plane_q   <= 4'd0;
      row_cnt_q <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      blank_q   <= 8'd0;
      out_q     <= SCAN_OUT_RESET;
      row_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      plane_q   <= plane_d;
      row_cnt_q <= row_cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      blank_q   <= blank_d;
      out_q     <= out_d;
      row_q     <= row_d;
    end
  end

  assign sr_data     = out_q.sr_data;
  assign sr_clk      = out_q.sr_clk;
  assign sr_latch    = out_q.sr_latch;
  assign sr_oe_n     = out_q.sr_oe_n;
  assign frame_start = out_q.frame_start;
  assign row         = row_q;

endmodule
